axi_stream_burst_writer: RTL and testbench

- Upstream AXI4 write master for ddr_sdram_ctrl.
- Accepts a valid/ready word stream, buffers it in an internal FIFO and packs it into fixed-length INCR write bursts on the AW/W/B channels, at linearly increasing byte addresses.
- A flush request forces out a partial burst.
- The top level ties the controller's read channel off (arvalid=0) when this block is the only master.

---
 rtl/axi_stream_burst_writer.sv | 176 +++++++++++++++++
 tb/tb_axi_stream_burst_writer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_burst_writer.sv
`default_nettype none
// ============================================================================
// Module : axi_stream_burst_writer
// Buffers a valid/ready word stream in a FWFT FIFO and writes it out as INCR
// AXI write bursts at linearly increasing byte addresses; flush forces a partial burst.
// Rev    : 1.0
// ============================================================================
module axi_stream_burst_writer #(
  parameter int unsigned         A_WIDTH     = 25,
  parameter int unsigned         D_WIDTH     = 16,
  parameter int unsigned         D_LEVEL     = 1,
  parameter logic [7:0]          BURST_LEN   = 8'd15,
  parameter int unsigned         FIFO_AWIDTH = 5,
  parameter logic [A_WIDTH-1:0]  BASE_ADDR   = '0
) (
  input  logic               rstn,
  input  logic               clk,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [D_WIDTH-1:0] i_data,
  input  logic               i_flush,
  output logic               o_flush_done,
  output logic               o_busy,
  output logic [31:0]        o_beat_cnt,
  output logic               awvalid,
  input  logic               awready,
  output logic [A_WIDTH-1:0] awaddr,
  output logic [7:0]         awlen,
  output logic               wvalid,
  input  logic               wready,
  output logic               wlast,
  output logic [D_WIDTH-1:0] wdata,
  input  logic               bvalid,
  output logic               bready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AW   = 2'd1,
    S_W    = 2'd2,
    S_B    = 2'd3
  } state_t;

  localparam logic [FIFO_AWIDTH:0] FULL_CNT   = {1'b1, {FIFO_AWIDTH{1'b0}}};
  localparam logic [31:0]          FULL_BEATS = 32'(BURST_LEN) + 32'd1;

  state_t                   state_q, state_d;
  logic [D_WIDTH-1:0]       fifo_mem [0:(1<<FIFO_AWIDTH)-1];
  logic [FIFO_AWIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AWIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AWIDTH:0]     count_q, count_d;
  logic                     i_ready_q, i_ready_d;
  logic                     flush_pending_q, flush_pending_d;
  logic [A_WIDTH-1:0]       awaddr_q, awaddr_d;
  logic [7:0]               awlen_q, awlen_d;
  logic [7:0]               beat_q, beat_d;
  logic [31:0]              beat_cnt_q, beat_cnt_d;

  logic                     push;
  logic                     pop;
  logic                     full_ready;
  logic                     flush_empty;
  logic [31:0]              count_ext;
  logic [8:0]               burst_beats;

  assign awvalid      = (state_q == S_AW);
  assign wvalid       = (state_q == S_W);
  assign bready       = (state_q == S_B);
  assign wlast        = wvalid && (beat_q == awlen_q);
  // Data bus is held at zero outside the W phase so reset leaves it quiet.
  assign wdata        = wvalid ? fifo_mem[rd_ptr_q] : '0;
  assign awaddr       = awaddr_q;
  assign awlen        = awlen_q;
  assign i_ready      = i_ready_q;
  assign o_beat_cnt   = beat_cnt_q;
  assign o_busy       = (state_q != S_IDLE) || (count_q != '0);
  assign o_flush_done = flush_empty;

  assign push         = i_valid && i_ready_q;
  assign pop          = wvalid && wready;
  assign count_ext    = 32'(count_q);
  assign full_ready   = (count_ext >= FULL_BEATS);
  assign burst_beats  = {1'b0, awlen_q} + 9'd1;
  assign flush_empty  = (state_q == S_IDLE) && !full_ready && flush_pending_q && (count_q == '0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    i_ready_d = (count_d != FULL_CNT);
  end

  always_comb begin
    state_d         = state_q;
    awaddr_d        = awaddr_q;
    awlen_d         = awlen_q;
    beat_d          = beat_q;
    beat_cnt_d      = beat_cnt_q;
    flush_pending_d = flush_pending_q | i_flush;
    case (state_q)
      S_IDLE: begin
        // A full burst takes priority over a pending flush.
        if (full_ready) begin
          awlen_d = BURST_LEN;
          state_d = S_AW;
        end else if (flush_pending_q && (count_q != '0)) begin
          awlen_d = 8'(count_ext - 32'd1);
          state_d = S_AW;
        end else if (flush_pending_q) begin
          flush_pending_d = 1'b0;
        end
      end
      S_AW: begin
        if (awready) begin
          beat_d  = '0;
          state_d = S_W;
        end
      end
      S_W: begin
        if (wready) begin
          beat_d = beat_q + 8'd1;
          if (wlast) begin
            state_d = S_B;
          end
        end
      end
      S_B: begin
        if (bvalid) begin
          state_d    = S_IDLE;
          beat_cnt_d = beat_cnt_q + 32'(burst_beats);
          awaddr_d   = awaddr_q + (A_WIDTH'(burst_beats) << D_LEVEL);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      i_ready_q       <= 1'b0;
      flush_pending_q <= 1'b0;
      awaddr_q        <= BASE_ADDR;
      awlen_q         <= '0;
      beat_q          <= '0;
      beat_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      i_ready_q       <= i_ready_d;
      flush_pending_q <= flush_pending_d;
      awaddr_q        <= awaddr_d;
      awlen_q         <= awlen_d;
      beat_q          <= beat_d;
      beat_cnt_q      <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_burst_writer.sv
`default_nettype none
// Directed bench for axi_stream_burst_writer: a queue-based model of accepted words,
// burst addresses and beat totals is checked every cycle, plus literal checkpoints.
module tb_axi_stream_burst_writer;

  localparam logic [24:0] BASE = 25'h1FFFFE0;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [15:0] i_data = '0;
  logic        i_flush = 1'b0;
  logic        o_flush_done;
  logic        o_busy;
  logic [31:0] o_beat_cnt;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [24:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid;
  logic        wready = 1'b0;
  logic        wlast;
  logic [15:0] wdata;
  logic        bvalid = 1'b0;
  logic        bready;

  bit rand_mode = 1'b1;
  bit aw_en = 1'b1;
  bit w_tog = 1'b0;
  bit b_en = 1'b1;
  bit chk_en = 1'b0;
  int cyc = 0;

  int tests = 0;
  int fails = 0;

  logic [15:0] q[$];
  int          exp_len[$];
  int          aw_idx = 0;
  logic [24:0] m_addr = BASE;
  logic [31:0] m_beats = '0;
  bit          in_burst = 1'b0;
  int          cur_len = 0;
  int          beat_idx = 0;
  bit          aw_stall = 1'b0;
  bit          w_stall = 1'b0;
  logic [24:0] prev_awaddr = '0;
  logic [7:0]  prev_awlen = '0;
  int          n_fd = 0;
  logic [24:0] seen_awaddr = '0;
  logic [15:0] last_data = '0;

  axi_stream_burst_writer #(
    .A_WIDTH(25), .D_WIDTH(16), .D_LEVEL(1), .BURST_LEN(8'd15),
    .FIFO_AWIDTH(5), .BASE_ADDR(BASE)
  ) dut (
    .rstn(rstn), .clk(clk),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .i_flush(i_flush), .o_flush_done(o_flush_done), .o_busy(o_busy),
    .o_beat_cnt(o_beat_cnt),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // AXI slave responder; changes land 2 time units after the edge.
  always @(posedge clk) begin
    #2;
    if (rand_mode) begin
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      bvalid  = 1'($urandom_range(0, 1));
    end else begin
      awready = aw_en;
      wready  = w_tog ? ~wready : 1'b1;
      bvalid  = b_en;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp_v);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: actual=event required=none", nm);
  endtask

  // One cycle of the model: checks current outputs, then accounts for the
  // handshakes that the coming rising edge will complete.
  task automatic compare_step();
    logic [15:0] hd;
    if (!rstn) begin
      q.delete();
      in_burst = 1'b0;
      m_addr   = BASE;
      m_beats  = '0;
      aw_stall = 1'b0;
      w_stall  = 1'b0;
      aw_idx   = exp_len.size();
      return;
    end
    if (!chk_en) return;
    if (aw_stall) begin
      chk("aw_hold_valid", awvalid, 1'b1);
      chk("aw_hold_addr", awaddr, prev_awaddr);
      chk("aw_hold_len", awlen, prev_awlen);
    end
    if (w_stall) chk("w_hold_valid", wvalid, 1'b1);
    chk("beat_cnt", o_beat_cnt, m_beats);
    chk("i_ready", i_ready, q.size() != 32);
    if (q.size() != 0 || in_burst) chk("busy", o_busy, 1'b1);
    if (o_flush_done) begin
      n_fd++;
      chk("flush_done_idle", q.size() + int'(in_burst), 0);
    end
    if (!wvalid) chk("wlast_idle", wlast, 1'b0);
    aw_stall    = awvalid && !awready;
    w_stall     = wvalid && !wready;
    prev_awaddr = awaddr;
    prev_awlen  = awlen;
    if (awvalid && awready) begin
      if (aw_idx >= exp_len.size()) begin
        fail_now("aw_unexpected");
      end else begin
        cur_len = exp_len[aw_idx];
        aw_idx++;
        chk("awlen", awlen, cur_len);
        chk("awaddr", awaddr, m_addr);
        seen_awaddr = awaddr;
        beat_idx = 0;
        in_burst = 1'b1;
      end
    end
    if (wvalid) begin
      chk("wlast", wlast, beat_idx == cur_len);
      if (q.size() == 0) fail_now("w_underflow");
      else chk("wdata", wdata, q[0]);
    end
    if (wvalid && wready && q.size() != 0) begin
      hd = q.pop_front();
      if (wlast) last_data = hd;
      beat_idx++;
    end
    if (bvalid && bready) begin
      m_beats  = m_beats + 32'(cur_len + 1);
      m_addr   = m_addr + 25'((cur_len + 1) * 2);
      in_burst = 1'b0;
    end
    if (i_valid && i_ready) q.push_back(i_data);
  endtask

  task automatic push_word(input logic [15:0] v);
    bit ok = 1'b0;
    i_valid = 1'b1;
    i_data  = v;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (i_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("push_timeout");
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (o_busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) fail_now("idle_timeout");
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input string nm, input bit is_w);
    bit ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if ((is_w ? wvalid : awvalid) == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now(nm);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_awvalid"}, awvalid, 1'b0);
    chk({tag, "_wvalid"}, wvalid, 1'b0);
    chk({tag, "_wlast"}, wlast, 1'b0);
    chk({tag, "_bready"}, bready, 1'b0);
    chk({tag, "_awaddr"}, awaddr, BASE);
    chk({tag, "_awlen"}, awlen, 8'd0);
    chk({tag, "_wdata"}, wdata, 16'd0);
    chk({tag, "_i_ready"}, i_ready, 1'b0);
    chk({tag, "_flush_done"}, o_flush_done, 1'b0);
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_beat_cnt"}, o_beat_cnt, 32'd0);
  endtask

  initial begin
    int t_ret;
    int fd0;
    int aw0;
    bit seen;
    fork
      forever begin
        @(negedge clk);
        compare_step();
      end
    join_none

    // Reset with random inputs
    #1 rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      i_valid = 1'($urandom_range(0, 1));
      i_data  = 16'($urandom);
      i_flush = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_reset_vals("rst");
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
    rand_mode = 1'b0;
    @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", i_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_edge", i_ready, 1'b1);
    chk_en = 1'b1;
    @(posedge clk);
    #1;

    // Full bursts (the second one wraps the address to zero)
    exp_len.push_back(15);
    for (int i = 0; i < 16; i++) push_word(16'(i));
    t_ret = cyc;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (awvalid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("aw_latency_timeout");
    else chk("aw_latency", cyc - t_ret, 1);
    wait_idle();
    chk("full1_beats", o_beat_cnt, 32'd16);
    chk("full1_addr", seen_awaddr, 25'h1FFFFE0);
    chk("full1_last", last_data, 16'h000F);
    exp_len.push_back(15);
    for (int i = 16; i < 32; i++) push_word(16'(i));
    wait_idle();
    chk("full2_beats", o_beat_cnt, 32'd32);
    chk("full2_addr", seen_awaddr, 25'h0000000);

    // Backpressure: AW held off, W ready toggling
    aw_en = 1'b0;
    exp_len.push_back(15);
    for (int i = 0; i < 16; i++) push_word(16'h0100 + 16'(i));
    wait_sig("bp_aw_timeout", 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    aw_en = 1'b1;
    w_tog = 1'b1;
    wait_idle();
    w_tog = 1'b0;
    chk("bp_beats", o_beat_cnt, 32'd48);
    chk("bp_addr", seen_awaddr, 25'h0000020);
    chk("bp_last", last_data, 16'h010F);

    // Partial flush of 5 words
    fd0 = n_fd;
    exp_len.push_back(4);
    for (int i = 0; i < 5; i++) push_word(16'h0200 + 16'(i));
    i_flush = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;
    wait_idle();
    chk("flush_pulses", n_fd - fd0, 1);
    chk("flush_beats", o_beat_cnt, 32'd53);
    chk("flush_last", last_data, 16'h0204);
    chk("flush_addr", seen_awaddr, 25'h0000040);

    // Flush with empty FIFO
    aw0 = aw_idx;
    i_flush = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;
    @(negedge clk);
    chk("eflush_pulse", o_flush_done, 1'b1);
    @(negedge clk);
    chk("eflush_single", o_flush_done, 1'b0);
    repeat (3) @(negedge clk);
    chk("eflush_no_aw", aw_idx, aw0);
    @(posedge clk);
    #1;

    // FIFO full: 40 words with AW stalled, then drained as 16+16+8
    aw_en = 1'b0;
    exp_len.push_back(15);
    exp_len.push_back(15);
    exp_len.push_back(7);
    for (int i = 0; i < 32; i++) push_word(16'h0300 + 16'(i));
    i_valid = 1'b1;
    i_data  = 16'h0320;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_ready_low", i_ready, 1'b0);
    end
    chk("full_accepted", q.size(), 32);
    @(posedge clk);
    #1;
    aw_en = 1'b1;
    for (int i = 32; i < 40; i++) push_word(16'h0300 + 16'(i));
    fd0 = n_fd;
    i_flush = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;
    wait_idle();
    chk("ffull_beats", o_beat_cnt, 32'd93);
    chk("ffull_last", last_data, 16'h0327);
    chk("ffull_addr", seen_awaddr, 25'h000008A);
    chk("ffull_flush", n_fd - fd0, 1);
    chk("ffull_bursts", aw_idx, exp_len.size());

    // Reset in the middle of the W phase
    exp_len.push_back(15);
    for (int i = 0; i < 16; i++) push_word(16'h0400 + 16'(i));
    wait_sig("midw_timeout", 1'b1);
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("midw_wvalid", wvalid, 1'b0);
    chk("midw_wlast", wlast, 1'b0);
    chk("midw_awvalid", awvalid, 1'b0);
    chk("midw_bready", bready, 1'b0);
    chk("midw_awaddr", awaddr, BASE);
    chk("midw_beats", o_beat_cnt, 32'd0);
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_ready", i_ready, 1'b1);
    chk("post_rst_empty", o_busy, 1'b0);
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    exp_len.push_back(15);
    for (int i = 0; i < 16; i++) push_word(16'h0500 + 16'(i));
    wait_idle();
    chk("post_rst_beats", o_beat_cnt, 32'd16);
    chk("post_rst_addr", seen_awaddr, 25'h1FFFFE0);
    chk("post_rst_last", last_data, 16'h050F);
    chk("post_rst_bursts", aw_idx, exp_len.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
